// File: rtl/brisc_pkg.sv
// Shared constants and types for the brisc core.
// Holds the memory-arbiter state enum and the bus-width defaults.
package brisc_pkg;

   // Width of a physical address on the main-memory port.
   localparam int ADDRESS_WIDTH = 32;

   // Width of one cache line moved on the main-memory port.
   localparam int CACHE_LINE_WIDTH = 256;

   // Upper bound on requesters sharing the memory port.
   localparam int ARB_MAX_PORTS = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker.
// Ports:
//   req   - request vector, one bit per port
//   ptr   - index of the highest-priority port
//   found - some request bit is set
//   index - first requesting port at or above ptr, wrapping
module rr_pick #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] index
);

   localparam int DW = 2 * N;
   localparam int JW = $clog2(DW);

   logic [DW-1:0] dbl;
   logic [DW-1:0] lo_mask;
   logic [DW-1:0] masked;
   logic [JW-1:0] j;

   // The vector is doubled so the wrap-around case is just a
   // plain lowest-bit search: bits below ptr are cleared in the
   // lower copy, the upper copy catches ports below ptr.
   assign dbl     = {req, req};
   assign lo_mask = (DW'(1) << ptr) - DW'(1);
   assign masked  = dbl & ~lo_mask;

   // Scan downward so the lowest set bit is the one kept.
   always_comb begin
      found = 1'b0;
      j     = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         if (masked[i]) begin
            found = 1'b1;
            j     = JW'(i);
         end
      end
   end

   assign index = (j >= JW'(N)) ? IW'(j - JW'(N)) : IW'(j);

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter for the shared main-memory port, fixed or
// round-robin priority, grant held until the owner drops req.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req/write/addr/wdata - per-port request bundle (packed arrays)
//   grant, owner, busy  - current ownership
//   mem_req/mem_write/mem_addr/mem_data - routed memory request
module mem_arbiter_rr
   import brisc_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = ADDRESS_WIDTH,
   parameter int DATA_W      = CACHE_LINE_WIDTH,
   parameter int ROUND_ROBIN = 1,
   localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS-1:0]            write,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata,
   output logic [NUM_PORTS-1:0]            grant,
   output logic [OW-1:0]                   owner,
   output logic                            busy,
   output logic                            mem_req,
   output logic                            mem_write,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_data
);

   arb_state_e    state_q;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] ptr_q;

   logic [OW-1:0] pick_ptr;
   logic [OW-1:0] win;
   logic [OW-1:0] nxt_ptr;
   logic          found;

   // Fixed priority is the rotating picker pinned at port 0.
   assign pick_ptr = (ROUND_ROBIN != 0) ? ptr_q : '0;

   rr_pick #(
      .N (NUM_PORTS)
   ) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (found),
      .index (win)
   );

   // Port after the winner becomes top priority next time.
   assign nxt_ptr = (win == OW'(NUM_PORTS - 1)) ? '0
                                                : win + OW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (found) begin
                  state_q <= ARB_BUSY;
                  owner_q <= win;
                  if (ROUND_ROBIN != 0) begin
                     ptr_q <= nxt_ptr;
                  end
               end
            end
            ARB_BUSY: begin
               // No preemption: only the owner's release matters.
               if (!req[owner_q]) begin
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   // Everything reads as zero while idle; while busy the owner's
   // bundle is muxed straight through, so mem_req falls in the
   // same cycle the owner drops req.
   always_comb begin
      grant     = '0;
      owner     = '0;
      busy      = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      if (state_q == ARB_BUSY) begin
         grant[owner_q] = 1'b1;
         owner          = owner_q;
         busy           = 1'b1;
         mem_req        = req[owner_q];
         mem_write      = write[owner_q];
         mem_addr       = addr[owner_q];
         mem_data       = wdata[owner_q];
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-port fixed-priority
// instance and a 4-port round-robin instance on a shared reset.
module tb_mem_arbiter_rr;

   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // fixed-priority instance
   logic [1:0]         f_req, f_write;
   logic [1:0][AW-1:0] f_addr;
   logic [1:0][DW-1:0] f_wdata;
   logic [1:0]         f_grant;
   logic [0:0]         f_owner;
   logic               f_busy, f_mreq, f_mwrite;
   logic [AW-1:0]      f_maddr;
   logic [DW-1:0]      f_mdata;

   // round-robin instance
   logic [3:0]         r_req, r_write;
   logic [3:0][AW-1:0] r_addr;
   logic [3:0][DW-1:0] r_wdata;
   logic [3:0]         r_grant;
   logic [1:0]         r_owner;
   logic               r_busy, r_mreq, r_mwrite;
   logic [AW-1:0]      r_maddr;
   logic [DW-1:0]      r_mdata;

   mem_arbiter_rr #(
      .NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)
   ) u_fix (
      .clk(clk), .reset(reset), .req(f_req), .write(f_write),
      .addr(f_addr), .wdata(f_wdata), .grant(f_grant),
      .owner(f_owner), .busy(f_busy), .mem_req(f_mreq),
      .mem_write(f_mwrite), .mem_addr(f_maddr), .mem_data(f_mdata)
   );

   mem_arbiter_rr #(
      .NUM_PORTS(4), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)
   ) u_rr (
      .clk(clk), .reset(reset), .req(r_req), .write(r_write),
      .addr(r_addr), .wdata(r_wdata), .grant(r_grant),
      .owner(r_owner), .busy(r_busy), .mem_req(r_mreq),
      .mem_write(r_mwrite), .mem_addr(r_maddr), .mem_data(r_mdata)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // own < 0 means idle (all outputs zero)
   task automatic chk_f(input string t, input int own, input bit mreq);
      logic [1:0] g;
      logic w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      #1;
      g = '0; w = 1'b0; a = '0; d = '0;
      if (own >= 0) begin
         g[own] = 1'b1;
         w = f_write[own];
         a = f_addr[own];
         d = f_wdata[own];
      end
      chk({t, " f.grant"}, 64'(f_grant), 64'(g));
      chk({t, " f.busy"}, 64'(f_busy), 64'(own >= 0));
      chk({t, " f.owner"}, 64'(f_owner), (own >= 0) ? 64'(own) : 64'd0);
      chk({t, " f.mem_req"}, 64'(f_mreq), 64'(mreq));
      chk({t, " f.mem_write"}, 64'(f_mwrite), 64'(w));
      chk({t, " f.mem_addr"}, 64'(f_maddr), 64'(a));
      chk({t, " f.mem_data"}, 64'(f_mdata), 64'(d));
   endtask

   task automatic chk_r(input string t, input int own, input bit mreq);
      logic [3:0] g;
      logic w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      #1;
      g = '0; w = 1'b0; a = '0; d = '0;
      if (own >= 0) begin
         g[own] = 1'b1;
         w = r_write[own];
         a = r_addr[own];
         d = r_wdata[own];
      end
      chk({t, " r.grant"}, 64'(r_grant), 64'(g));
      chk({t, " r.onehot0"}, 64'($onehot0(r_grant)), 64'd1);
      chk({t, " r.busy"}, 64'(r_busy), 64'(own >= 0));
      chk({t, " r.owner"}, 64'(r_owner), (own >= 0) ? 64'(own) : 64'd0);
      chk({t, " r.mem_req"}, 64'(r_mreq), 64'(mreq));
      chk({t, " r.mem_write"}, 64'(r_mwrite), 64'(w));
      chk({t, " r.mem_addr"}, 64'(r_maddr), 64'(a));
      chk({t, " r.mem_data"}, 64'(r_mdata), 64'(d));
   endtask

   typedef struct {
      logic [1:0] req;
      int         own;
      bit         mreq;
      string      nm;
   } fvec_t;

   fvec_t fv[11];
   int    ord[5];

   initial begin
      fv[0]  = '{2'b11, -1, 1'b0, "fx c0 idle"};
      fv[1]  = '{2'b11,  0, 1'b1, "fx c1 p0"};
      fv[2]  = '{2'b11,  0, 1'b1, "fx c2 p0"};
      fv[3]  = '{2'b10,  0, 1'b0, "fx c3 p0 rel"};
      fv[4]  = '{2'b10, -1, 1'b0, "fx c4 gap"};
      fv[5]  = '{2'b10,  1, 1'b1, "fx c5 p1"};
      fv[6]  = '{2'b00,  1, 1'b0, "fx c6 p1 rel"};
      fv[7]  = '{2'b11, -1, 1'b0, "fx c7 idle"};
      fv[8]  = '{2'b11,  0, 1'b1, "fx c8 p0 wins"};
      fv[9]  = '{2'b00,  0, 1'b0, "fx c9 rel"};
      fv[10] = '{2'b00, -1, 1'b0, "fx c10 idle"};
      ord = '{0, 1, 2, 3, 0};

      reset   = 1'b1;
      f_req   = 2'b11;
      f_write = 2'b10;
      f_addr[0]  = 16'h0A00;
      f_addr[1]  = 16'h0B00;
      f_wdata[0] = 32'h1111_1111;
      f_wdata[1] = 32'h2222_2222;
      r_req   = '0;
      r_write = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         r_addr[i]  = AW'(16'h100 * (i + 1));
         r_wdata[i] = {16'hC0DE, 8'(i), 8'(~i)};
      end

      // reset with requests pending
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_f("rst first", -1, 1'b0);
      chk_r("rst first", -1, 1'b0);
      nxt();
      chk_f("rst grant", 0, 1'b1);
      nxt(); f_req = 2'b00;
      chk_f("rst rel", 0, 1'b0);
      nxt();
      chk_f("rst idle", -1, 1'b0);

      // fixed-priority table
      for (int k = 0; k < 11; k++) begin
         nxt();
         f_req = fv[k].req;
         chk_f(fv[k].nm, fv[k].own, fv[k].mreq);
      end

      // round-robin: all request, each holds 2 granted cycles
      nxt(); r_req = 4'b1111;
      chk_r("rr start", -1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         nxt();
         chk_r($sformatf("rr t%0d g1", k), ord[k], 1'b1);
         nxt();
         chk_r($sformatf("rr t%0d g2", k), ord[k], 1'b1);
         nxt(); r_req[ord[k]] = 1'b0;
         chk_r($sformatf("rr t%0d rel", k), ord[k], 1'b0);
         nxt(); r_req = (k == 4) ? 4'b0000 : 4'b1111;
         chk_r($sformatf("rr t%0d gap", k), -1, 1'b0);
      end

      // release coinciding with a new request from port 2
      nxt(); r_req = 4'b0010;
      chk_r("sim idle", -1, 1'b0);
      nxt();
      chk_r("sim p1", 1, 1'b1);
      nxt(); r_req = 4'b0100;
      chk_r("sim rel", 1, 1'b0);
      nxt();
      chk_r("sim gap", -1, 1'b0);
      nxt();
      chk_r("sim p2", 2, 1'b1);
      nxt(); r_req = 4'b0000;
      chk_r("sim p2 rel", 2, 1'b0);
      nxt();
      chk_r("sim end", -1, 1'b0);

      // reset while port 1 owns with write set
      nxt(); r_req = 4'b0010;
      chk_r("mr idle", -1, 1'b0);
      nxt();
      chk_r("mr p1 wr", 1, 1'b1);
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      r_req = 4'b1000;
      chk_r("mr after rst", -1, 1'b0);
      chk_f("mr after rst", -1, 1'b0);
      nxt();
      chk_r("mr p3", 3, 1'b1);
      nxt(); r_req = 4'b0000;
      chk_r("mr p3 rel", 3, 1'b0);
      nxt();
      chk_r("mr end", -1, 1'b0);

      // pointer must return to 0 on reset (ptr=2 would pick 3)
      nxt(); r_req = 4'b0010;
      chk_r("pr idle", -1, 1'b0);
      nxt();
      chk_r("pr p1", 1, 1'b1);
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      r_req = 4'b1010;
      chk_r("pr after rst", -1, 1'b0);
      nxt();
      chk_r("pr ptr0 p1", 1, 1'b1);
      nxt(); r_req = 4'b0000;
      chk_r("pr rel", 1, 1'b0);
      nxt();
      chk_r("pr end", -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
